// File: rtl/qsys_pio_led_pkg.sv
// qsys_pio_led_pkg
//   Shared constants for the LED blink PIO: register word addresses and the
//   width of the PRESCALE/HALF fields.
package qsys_pio_led_pkg;
    localparam int FIELD_W = 16;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MODE     = 3'd1;
    localparam logic [2:0] ADDR_PRESCALE = 3'd2;
    localparam logic [2:0] ADDR_HALF     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;
endpackage

// File: rtl/qsys_led_blink_timer.sv
// qsys_led_blink_timer
//   Prescaler + blink half-period counter producing the shared blink phase.
//   Ports:
//     clk, reset_n  clock, synchronous active-low reset
//     restart       clear both counters and force phase=1 (no tick this cycle)
//     prescale      tick period is prescale+1 clk cycles
//     half          blink half-period in ticks (0 behaves as 1)
//     tick          one-cycle tick pulse
//     phase         blink phase (1 = LED on for blinking channels)
module qsys_led_blink_timer
    import qsys_pio_led_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               restart,
    input  logic [FIELD_W-1:0] prescale,
    input  logic [FIELD_W-1:0] half,
    output logic               tick,
    output logic               phase
);
    logic [FIELD_W-1:0] r_pcnt;
    logic [FIELD_W-1:0] r_bcnt;
    logic               r_phase;
    logic [FIELD_W-1:0] w_half_m1;

    // max(half,1)-1: HALF=0 blinks like HALF=1
    assign w_half_m1 = (half == '0) ? '0 : half - 16'd1;
    assign tick      = (r_pcnt == prescale) && !restart;
    assign phase     = r_phase;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pcnt  <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (restart) begin
            r_pcnt  <= '0;
            r_bcnt  <= '0;
            r_phase <= 1'b1;
        end else if (tick) begin
            r_pcnt <= '0;
            if (r_bcnt >= w_half_m1) begin
                r_bcnt  <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_bcnt <= r_bcnt + 16'd1;
            end
        end else begin
            r_pcnt <= r_pcnt + 16'd1;
        end
    end
endmodule

// File: rtl/qsys_pio_led_blink.sv
// qsys_pio_led_blink
//   Avalon-MM slave LED port with per-channel static/blink mode.
//   Ports:
//     clk, reset_n          clock, synchronous active-low reset
//     address/chipselect/write_n/writedata   Avalon-MM write side
//     readdata              combinational read data, zero-extended
//     out_port              registered LED drive, WIDTH bits
module qsys_pio_led_blink
    import qsys_pio_led_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_RESET = 49999,
    parameter int HALF_RESET     = 500
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_mode;
    logic [FIELD_W-1:0] r_prescale;
    logic [FIELD_W-1:0] r_half;
    logic [WIDTH-1:0]   r_out;
    logic               w_wr;
    logic               w_restart;
    logic               w_tick;
    logic               w_phase;
    logic               w_unused;

    assign w_wr      = chipselect && !write_n;
    assign w_restart = w_wr && (address == ADDR_PRESCALE || address == ADDR_HALF);
    assign w_unused  = ^{writedata[31:FIELD_W], w_tick};
    assign out_port  = r_out;

    qsys_led_blink_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .restart  (w_restart),
        .prescale (r_prescale),
        .half     (r_half),
        .tick     (w_tick),
        .phase    (w_phase)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data     <= '0;
            r_mode     <= '0;
            r_prescale <= FIELD_W'(PRESCALE_RESET);
            r_half     <= FIELD_W'(HALF_RESET);
            r_out      <= '0;
        end else begin
            // Output uses pre-edge DATA/MODE/phase, so updates show one cycle later.
            r_out <= r_data & (~r_mode | {WIDTH{w_phase}});
            if (w_wr) begin
                case (address)
                    ADDR_DATA:     r_data     <= writedata[WIDTH-1:0];
                    ADDR_MODE:     r_mode     <= writedata[WIDTH-1:0];
                    ADDR_PRESCALE: r_prescale <= writedata[FIELD_W-1:0];
                    ADDR_HALF:     r_half     <= writedata[FIELD_W-1:0];
                    ADDR_OUTSET:   r_data     <= r_data | writedata[WIDTH-1:0];
                    ADDR_OUTCLR:   r_data     <= r_data & ~writedata[WIDTH-1:0];
                    default:       ;
                endcase
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0]   = r_data;
            ADDR_MODE:     readdata[WIDTH-1:0]   = r_mode;
            ADDR_PRESCALE: readdata[FIELD_W-1:0] = r_prescale;
            ADDR_HALF:     readdata[FIELD_W-1:0] = r_half;
            ADDR_STATUS:   readdata[0]           = w_phase;
            default:       ;
        endcase
    end
endmodule

// File: tb/tb_qsys_pio_led_blink.sv
module tb_qsys_pio_led_blink;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents plus the number of edges since the
    // last counter restart; the phase is derived arithmetically from that.
    logic [7:0]  m_data, m_mode, m_out;
    logic [15:0] m_pre, m_half;
    int          m_n;

    qsys_pio_led_blink dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    function automatic logic mphase();
        int heff  = (m_half == 0) ? 1 : int'(m_half);
        int ticks = m_n / (int'(m_pre) + 1);
        return 1'b1 ^ 1'((ticks / heff) & 1);
    endfunction

    function automatic logic [31:0] mread(input logic [2:0] a);
        case (a)
            3'd0: return {24'd0, m_data};
            3'd1: return {24'd0, m_mode};
            3'd2: return {16'd0, m_pre};
            3'd3: return {16'd0, m_half};
            3'd6: return {31'd0, mphase()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then check.
    task automatic cycle();
        logic [7:0] nout;
        logic       ph;
        logic       rs;
        @(posedge clk);
        ph = mphase();
        if (!reset_n) begin
            m_data = 0; m_mode = 0; m_pre = 16'd49999; m_half = 16'd500;
            m_n = 0; m_out = 0;
        end else begin
            nout = m_data & (~m_mode | {8{ph}});
            rs = 1'b0;
            if (chipselect && !write_n) begin
                case (address)
                    3'd0: m_data = writedata[7:0];
                    3'd1: m_mode = writedata[7:0];
                    3'd2: begin m_pre  = writedata[15:0]; rs = 1'b1; end
                    3'd3: begin m_half = writedata[15:0]; rs = 1'b1; end
                    3'd4: m_data = m_data | writedata[7:0];
                    3'd5: m_data = m_data & ~writedata[7:0];
                    default: ;
                endcase
            end
            m_n   = rs ? 0 : m_n + 1;
            m_out = nout;
        end
        #1;
        chk("out_port", {24'd0, out_port}, {24'd0, m_out});
        chk("readdata", readdata, mread(address));
    endtask

    task automatic do_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        cycle();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rb_exp [8];
        logic        prev;
        int          k;
        rb_exp = '{32'd0, 32'd0, 32'd49999, 32'd500, 32'd0, 32'd0, 32'd1, 32'd0};

        // Reset and readback of every address
        cycle(); cycle();
        reset_n = 1'b1;
        chk("reset_out", {24'd0, out_port}, 32'd0);
        for (int a = 0; a < 8; a++) begin
            address = 3'(a);
            #1;
            chk($sformatf("reset_rd%0d", a), readdata, rb_exp[a]);
        end
        cycle();

        // Static output, OUTSET/OUTCLR
        do_write(3'd0, 32'hFFFF_FFA5);
        chk("data_lat1", {24'd0, out_port}, 32'd0);
        cycle();
        chk("data_a5", {24'd0, out_port}, 32'hA5);
        do_write(3'd4, 32'h0000_000A);
        chk("outset_rd", readdata, 32'd0);
        cycle();
        chk("outset_af", {24'd0, out_port}, 32'hAF);
        do_write(3'd5, 32'h0000_0081);
        chk("outclr_rd", readdata, 32'd0);
        cycle();
        chk("outclr_2e", {24'd0, out_port}, 32'h2E);

        // Blink: PRESCALE=0, HALF=3, low nibble blinks
        do_write(3'd2, 32'hABCD_0000);
        do_write(3'd3, 32'h0000_0003);
        do_write(3'd0, 32'h0000_00FF);
        do_write(3'd1, 32'h0000_000F);
        address = 3'd6;
        for (int i = 0; i < 14; i++) begin
            cycle();
            chk("hi_nibble", {28'd0, out_port[7:4]}, 32'hF);
        end

        // HALF=0 behaves as HALF=1: toggles every cycle
        do_write(3'd3, 32'h0000_0000);
        cycle(); cycle();
        prev = out_port[0];
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("half0_toggle", {31'd0, out_port[0]}, {31'd0, ~prev});
            prev = out_port[0];
        end

        // Restart on PRESCALE write while phase=0
        do_write(3'd3, 32'h0000_0003);
        address = 3'd6;
        k = 0;
        while (readdata[0] !== 1'b0 && k < 20) begin cycle(); k++; end
        chk("phase0_reached", {31'd0, readdata[0]}, 32'd0);
        do_write(3'd2, 32'h0000_0004);
        address = 3'd6;
        #1;
        chk("restart_phase1", {31'd0, readdata[0]}, 32'd1);
        k = 0;
        while (k < 40) begin
            cycle(); k++;
            if (readdata[0] === 1'b0) break;
        end
        chk("restart_toggle_cycles", 32'(k), 32'd15);

        // Synchronous reset mid-blink
        do_write(3'd2, 32'h0000_0000);
        do_write(3'd1, 32'h0000_0003);
        cycle(); cycle();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        chk("rst_out", {24'd0, out_port}, 32'd0);
        address = 3'd2; #1;
        chk("rst_prescale", readdata, 32'd49999);
        address = 3'd3; #1;
        chk("rst_half", readdata, 32'd500);
        address = 3'd6; #1;
        chk("rst_status", readdata, 32'd1);

        // Pulse on reset_n between edges is ignored
        do_write(3'd0, 32'h0000_00FF);
        cycle();
        #1 reset_n = 1'b0;
        #3 reset_n = 1'b1;
        cycle();
        chk("async_ignored", {24'd0, out_port}, 32'hFF);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            address    = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom);
            write_n    = 1'($urandom);
            writedata  = $urandom;
            if (address == 3'd2 || address == 3'd3)
                writedata = (writedata & 32'hFFFF_0000) | 32'($urandom_range(0, 5));
            reset_n = ($urandom_range(0, 99) != 0);
            cycle();
        end
        reset_n = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
